// File: rtl/cntr_param_pkg.sv
// Shared types for the parametrised counter:
// per-cycle operation codes and control FSM states.
package cntr_param_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_DEC,
    OP_WRAP_UP,
    OP_WRAP_DN,
    OP_SAT,
    OP_LOAD,
    OP_CLEAR
  } cntr_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SAT
  } cntr_state_t;

  function automatic logic op_is_wrap(input cntr_op_t op);
    return (op == OP_WRAP_UP) || (op == OP_WRAP_DN);
  endfunction

endpackage

// File: rtl/cntr_param_control.sv
// Counter control: boundary compares, operation decode
// and the IDLE/RUN/SAT state register.
module cntr_param_control
  import cntr_param_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_sig,
  input  logic             dir,
  input  logic             wrap_mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] max_r,
  output cntr_op_t         operation,
  output cntr_state_t      state
);

  logic up_bnd;
  logic dn_bnd;
  logic at_bnd;

  // >= so a lowered terminal still catches a count above it
  assign up_bnd = cnt >= max_r;
  assign dn_bnd = cnt == '0;
  assign at_bnd = dir ? dn_bnd : up_bnd;

  always_comb begin
    operation = OP_HOLD;
    if (clr) begin
      operation = OP_CLEAR;
    end else if (load) begin
      operation = OP_LOAD;
    end else if (!en_sig) begin
      operation = OP_HOLD;
    end else if (!at_bnd) begin
      operation = dir ? OP_DEC : OP_INC;
    end else if (wrap_mode) begin
      operation = dir ? OP_WRAP_DN : OP_WRAP_UP;
    end else begin
      operation = OP_SAT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      unique case (operation)
        OP_CLEAR: state <= IDLE;
        OP_SAT:   state <= SAT;
        OP_HOLD:  state <= state;
        default:  state <= RUN;
      endcase
    end
  end

endmodule

// File: rtl/cntr_param.sv
// Parametrised counter datapath: count, terminal value
// and registered terminal-count pulse.
module cntr_param
  import cntr_param_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MAX_RST = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_sig,
  input  logic             dir,
  input  logic             wrap_mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             max_wr,
  input  logic [WIDTH-1:0] max_in,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output cntr_op_t         operation,
  output cntr_state_t      state
);

  localparam logic [WIDTH-1:0] MAX_INIT = WIDTH'(MAX_RST);

  logic [WIDTH-1:0] max_r;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] load_clamp;
  logic             tc_nxt;

  cntr_param_control #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .en_sig   (en_sig),
    .dir      (dir),
    .wrap_mode(wrap_mode),
    .clr      (clr),
    .load     (load),
    .cnt      (cnt_out),
    .max_r    (max_r),
    .operation(operation),
    .state    (state)
  );

  assign load_clamp = (load_val > max_r) ? max_r : load_val;

  always_comb begin
    cnt_nxt = cnt_out;
    unique case (operation)
      OP_CLEAR:   cnt_nxt = '0;
      OP_LOAD:    cnt_nxt = load_clamp;
      OP_INC:     cnt_nxt = cnt_out + 1'b1;
      OP_DEC:     cnt_nxt = cnt_out - 1'b1;
      OP_WRAP_UP: cnt_nxt = '0;
      OP_WRAP_DN: cnt_nxt = max_r;
      default:    cnt_nxt = cnt_out;
    endcase
  end

  // saturation only flags tc on the cycle it is entered
  assign tc_nxt = op_is_wrap(operation)
                | ((operation == OP_SAT) & (state != SAT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_out <= '0;
      tc      <= 1'b0;
      max_r   <= MAX_INIT;
    end else begin
      cnt_out <= cnt_nxt;
      tc      <= tc_nxt;
      if (max_wr) begin
        max_r <= max_in;
      end
    end
  end

endmodule

// File: tb/tb_cntr_param.sv
// Self-checking bench for cntr_param (WIDTH=8) against
// an arithmetic reference model, directed then random.
module tb_cntr_param;
  import cntr_param_pkg::*;

  logic        clk;
  logic        rst;
  logic        en_sig;
  logic        dir;
  logic        wrap_mode;
  logic        clr;
  logic        load;
  logic [7:0]  load_val;
  logic        max_wr;
  logic [7:0]  max_in;
  logic [7:0]  cnt_out;
  logic        tc;
  cntr_op_t    operation;
  cntr_state_t state;

  int total;
  int bad;

  int          m_cnt;
  int          m_max;
  bit          m_tc;
  cntr_state_t m_st;

  cntr_param #(
    .WIDTH(8),
    .MAX_RST(127)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en_sig   (en_sig),
    .dir      (dir),
    .wrap_mode(wrap_mode),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .max_wr   (max_wr),
    .max_in   (max_in),
    .cnt_out  (cnt_out),
    .tc       (tc),
    .operation(operation),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_max = 127;
    m_tc  = 1'b0;
    m_st  = IDLE;
  endtask

  // expected decision from the rules, using current inputs
  function automatic cntr_op_t exp_op();
    if (clr) return OP_CLEAR;
    if (load) return OP_LOAD;
    if (!en_sig) return OP_HOLD;
    if (!dir) begin
      if (m_cnt < m_max) return OP_INC;
      return wrap_mode ? OP_WRAP_UP : OP_SAT;
    end
    if (m_cnt > 0) return OP_DEC;
    return wrap_mode ? OP_WRAP_DN : OP_SAT;
  endfunction

  task automatic model_apply(input cntr_op_t op);
    int lv;
    lv = int'(load_val);
    case (op)
      OP_CLEAR:   m_cnt = 0;
      OP_LOAD:    m_cnt = (lv > m_max) ? m_max : lv;
      OP_INC:     m_cnt = m_cnt + 1;
      OP_DEC:     m_cnt = m_cnt - 1;
      OP_WRAP_UP: m_cnt = 0;
      OP_WRAP_DN: m_cnt = m_max;
      default:    m_cnt = m_cnt;
    endcase
    m_tc = (op == OP_WRAP_UP) || (op == OP_WRAP_DN) ||
           (op == OP_SAT && m_st != SAT);
    if (op == OP_CLEAR) m_st = IDLE;
    else if (op == OP_SAT) m_st = SAT;
    else if (op != OP_HOLD) m_st = RUN;
    if (max_wr) m_max = int'(max_in);
  endtask

  task automatic cyc(input logic e, input logic d,
                     input logic w, input logic c,
                     input logic l, input logic [7:0] lv,
                     input logic mw, input logic [7:0] mi);
    cntr_op_t op;
    en_sig    = e;
    dir       = d;
    wrap_mode = w;
    clr       = c;
    load      = l;
    load_val  = lv;
    max_wr    = mw;
    max_in    = mi;
    #2;
    op = exp_op();
    chk("op", operation, op);
    @(posedge clk);
    model_apply(op);
    #1;
    chk("cnt", cnt_out, m_cnt);
    chk("tc", tc, m_tc);
    chk("state", state, m_st);
  endtask

  initial begin
    bit rd;
    total = 0;
    bad   = 0;
    rst = 1'b0;
    en_sig = 0; dir = 0; wrap_mode = 0; clr = 0;
    load = 0; load_val = 0; max_wr = 0; max_in = 0;
    model_reset();
    #3;
    chk("rst_cnt", cnt_out, 0);
    chk("rst_tc", tc, 0);
    chk("rst_state", state, IDLE);
    chk("rst_op", operation, OP_HOLD);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // up count with wrap from reset
    for (int i = 0; i < 128; i++)
      cyc(1, 0, 1, 0, 0, 0, 0, 0);
    chk("wrap_up_cnt", cnt_out, 0);
    chk("wrap_up_tc", tc, 1);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    chk("after_wrap_tc", tc, 0);

    // down count with wrap from 2
    cyc(0, 1, 1, 0, 1, 8'd2, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 1, 0, 0, 0, 0, 0);
    chk("wrap_dn_cnt", cnt_out, 127);
    chk("wrap_dn_tc", tc, 1);

    // saturate up from 125
    cyc(0, 0, 0, 0, 1, 8'd125, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_cnt", cnt_out, 127);
    chk("sat_state", state, SAT);
    chk("sat_tc_once", tc, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("unsat_cnt", cnt_out, 126);
    chk("unsat_state", state, RUN);

    // priority and load clamp
    cyc(0, 0, 1, 0, 1, 8'd50, 0, 0);
    cyc(1, 0, 1, 1, 1, 8'd90, 0, 0);
    chk("prio_cnt", cnt_out, 0);
    chk("prio_state", state, IDLE);
    cyc(0, 0, 1, 0, 1, 8'd200, 0, 0);
    chk("clamp_cnt", cnt_out, 127);

    // lower terminal below the count
    cyc(0, 0, 1, 0, 1, 8'd40, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 1, 8'd10);
    chk("old_max_used", cnt_out, 41);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    chk("low_max_cnt", cnt_out, 0);
    chk("low_max_tc", tc, 1);
    cyc(1, 0, 1, 0, 0, 0, 1, 8'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 0, 0, 0, 0, 0);
      chk("max0_cnt", cnt_out, 0);
      chk("max0_tc", tc, 1);
    end

    // async reset with tc pending at 77
    cyc(0, 0, 1, 0, 0, 0, 1, 8'd77);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_cnt", cnt_out, 77);
    chk("pre_rst_tc", tc, 1);
    en_sig = 0; clr = 0; load = 0; max_wr = 0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_cnt", cnt_out, 0);
    chk("arst_tc", tc, 0);
    chk("arst_state", state, IDLE);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // random phase
    rd = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) rd = ~rd;
      cyc($urandom_range(0, 3) != 0, rd,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 40) == 0,
          $urandom_range(0, 20) == 0,
          8'($urandom_range(0, 255)),
          $urandom_range(0, 30) == 0,
          8'($urandom_range(0, 200)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cntr_param.md
# cntr_param

Parametrised successor to the fixed 0..127 counter control. It provides a WIDTH-bit counter with a programmable terminal value, up/down direction, wrap-or-saturate mode, synchronous clear and parallel load. A registered terminal-count pulse and a per-cycle operation code let downstream blocks and checkers observe the decision taken each cycle. It sits in the counter subsystem and replaces the hard-coded counter wherever a terminal value other than 127 or a down/saturating count is needed.

## Interface
- WIDTH, 32: counter and value width, 2..32.
- MAX_RST, 127: value of the internal terminal register after reset.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- en_sig  in  1  count enable.
- dir  in  1  0 = up, 1 = down.
- wrap_mode  in  1  1 = wrap at boundary, 0 = saturate.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  load value.
- max_wr  in  1  writes max_in into the terminal register.
- max_in  in  WIDTH  new terminal value.
- cnt_out  out  WIDTH  registered count.
- tc  out  1  registered terminal-count pulse.
- operation  out  cntr_op_t  combinational operation code for the current cycle.
- state  out  cntr_state_t  current FSM state.

## Operation
- The terminal register max_r resets to MAX_RST. When max_wr = 1 it loads max_in at the next edge, independently of the count operation.
- Boundaries:
  - up boundary: cnt_out >= max_r (covers max_r lowered below the count);
  - down boundary: cnt_out == 0.
- operation is decoded from state and inputs. Priority: clr > load > en_sig.
  - OP_CLEAR: cnt <= 0.
  - OP_LOAD: cnt <= min(load_val, max_r).
  - OP_HOLD: en_sig = 0; no change.
  - OP_INC / OP_DEC: en_sig = 1, not at the boundary for dir; cnt ± 1.
  - OP_WRAP_UP: up boundary, dir = 0, wrap_mode = 1; cnt <= 0, tc.
  - OP_WRAP_DN: down boundary, dir = 1, wrap_mode = 1; cnt <= max_r, tc.
  - OP_SAT: boundary for dir, wrap_mode = 0; cnt unchanged. tc is raised only on entry to SAT.
- FSM states:
  - IDLE: reset state.
    - en_sig, load or clr → RUN; the op still applies this cycle.
    - clr in IDLE stays in IDLE.
  - RUN:
    - OP_SAT → SAT.
    - clr → IDLE.
    - otherwise stays in RUN.
  - SAT:
    - clr → IDLE.
    - load → RUN.
    - en_sig with dir away from the boundary → RUN (OP_INC/OP_DEC applied).
    - en_sig toward the boundary → stays in SAT, OP_SAT, no tc.
    - wrap_mode raised while in SAT with en_sig toward the boundary → wrap op, tc, → RUN.
- Arithmetic: unsigned, modulo 2^WIDTH internally. cnt never exceeds max_r except after max_r is lowered; the next up-enable then wraps or saturates.
- max_r = 0, up, wrap: every enabled cycle is OP_WRAP_UP, cnt stays 0, and tc is high each enabled cycle.

## Timing
- Reset, async assert: cnt_out = 0, tc = 0, state = IDLE, max_r = MAX_RST. With en_sig = 0, operation = OP_HOLD.
- Deassertion is synchronised externally. The first active edge after deassertion acts normally.
- cnt_out, tc and state update on the rising edge following the op decision: 1-cycle latency from inputs.
- tc is high for exactly the cycle in which cnt_out shows the wrapped value (0 or max_r), or the first cycle in SAT.
- max_wr and a count op in the same cycle: the op uses the old max_r, and the new max_r is visible next cycle.
- Reset mid-count: immediate return to reset values. No pending tc survives.

## Structure
- Shared package cntr_param_pkg holds:
  - cntr_op_t: OP_HOLD, OP_INC, OP_DEC, OP_WRAP_UP, OP_WRAP_DN, OP_SAT, OP_LOAD, OP_CLEAR;
  - cntr_state_t: IDLE, RUN, SAT.
- Sub-module cntr_param_control holds the combinational op decode, the FSM and the boundary compares. It takes cnt_out and max_r as inputs.
- The top level holds the datapath: cnt register, max_r, tc register.

## Test plan
- WIDTH = 8, defaults, en_sig = 1, dir = 0, wrap_mode = 1 from reset → cnt 0..127, then 0.
  - tc is high only in the cycle cnt_out = 0 after 127.
  - operation = OP_WRAP_UP in the cycle cnt = 127.
- Down count with wrap from load_val = 2 → cnt 2, 1, 0, then 127; tc on 127; OP_WRAP_DN seen.
- wrap_mode = 0, up from 125 → 126, 127, then hold at 127.
  - state goes RUN → SAT; tc pulses once only.
  - dir = 1 → cnt 126, state RUN.
- Priority: clr = load = en_sig = 1 at cnt = 50 → cnt 0, OP_CLEAR, state IDLE.
  - load_val = 200 with max_r = 127 → cnt 127.
- max_wr with max_in = 10 while cnt = 40 (up, wrap) → next enabled cycle wraps to 0 with tc.
  - max_in = 0 → cnt stays 0 with tc every enabled cycle.
- rst asserted mid-count at cnt = 77 with tc pending → cnt_out = 0, tc = 0, state IDLE immediately, without waiting for clk.
